// File: rtl/sc_matrix_scheduler_pkg.sv
// Purpose: shared encodings and constants for the matrix display scheduler.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package sc_matrix_scheduler_pkg;

    // Main game state as presented by the top-level game FSM.
    localparam logic [1:0] MAIN_START    = 2'b00;
    localparam logic [1:0] MAIN_PLAY     = 2'b01;
    localparam logic [1:0] MAIN_GAMEOVER = 2'b10;
    localparam logic [1:0] MAIN_RSVD     = 2'b11;

    // Scheduler-local display state.
    typedef enum logic [1:0] {
        SCHED_SPLASH   = 2'd0,
        SCHED_PLAY     = 2'd1,
        SCHED_OVER_ON  = 2'd2,
        SCHED_OVER_OFF = 2'd3
    } sched_state_t;

    // Splash bitmap, one byte per row.
    localparam logic [7:0] SPLASH_ROW0 = 8'h10;
    localparam logic [7:0] SPLASH_ROW1 = 8'h00;
    localparam logic [7:0] SPLASH_ROW2 = 8'h10;
    localparam logic [7:0] SPLASH_ROW3 = 8'h38;
    localparam logic [7:0] SPLASH_ROW4 = 8'h7C;
    localparam logic [7:0] SPLASH_ROW5 = 8'h7C;
    localparam logic [7:0] SPLASH_ROW6 = 8'h38;
    localparam logic [7:0] SPLASH_ROW7 = 8'h10;

    // Row r sits at bits [8r+7:8r], matching the game frame layout.
    localparam logic [63:0] SPLASH_FRAME = {SPLASH_ROW7, SPLASH_ROW6, SPLASH_ROW5, SPLASH_ROW4,
                                            SPLASH_ROW3, SPLASH_ROW2, SPLASH_ROW1, SPLASH_ROW0};

    localparam logic [3:0] INTENSITY_SPLASH = 4'h6;
    localparam logic [3:0] INTENSITY_PLAY   = 4'hA;
    localparam logic [3:0] INTENSITY_OVER   = 4'hF;

    function automatic logic [3:0] intensity_for(input sched_state_t s);
        logic [3:0] val;
        case (s)
            SCHED_SPLASH: val = INTENSITY_SPLASH;
            SCHED_PLAY:   val = INTENSITY_PLAY;
            default:      val = INTENSITY_OVER;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/sc_matrix_transpose.sv
// Purpose: pick one column out of a row-major 8x8 frame (row0 lands in the MSB).
// Latency: combinational.
// Backpressure: none.
// Ports: frame (rows packed [8r+7:8r]), addr (column index), col (column byte).
module sc_matrix_transpose #(
    parameter int DATAWIDTH_BUS = 8
) (
    input  logic [DATAWIDTH_BUS*DATAWIDTH_BUS-1:0] frame,
    input  logic [$clog2(DATAWIDTH_BUS)-1:0]       addr,
    output logic [DATAWIDTH_BUS-1:0]               col
);

    // Column a reads bit (W-1-a) of every row; row r drives output bit (W-1-r).
    always_comb begin
        col = '0;
        for (int r = 0; r < DATAWIDTH_BUS; r++) begin
            col[DATAWIDTH_BUS-1-r] = frame[r*DATAWIDTH_BUS + (DATAWIDTH_BUS-1) - int'(addr)];
        end
    end

endmodule

// File: rtl/sc_matrix_scheduler.sv
// Purpose: owns the 8x8 picture; double-buffers game frames, commits on scan wrap, picks source/intensity.
// Latency: 1 cycle from addr/state to column byte and intensity; ack 1 cycle after valid; swap 1 cycle after wrap.
// Backpressure: none; every valid cycle is captured and the newest frame wins.
// Ports: clock/reset, main state, game frame + valid/ack, column address/data, intensity, frame swap pulse.
module sc_matrix_scheduler
    import sc_matrix_scheduler_pkg::*;
#(
    parameter int DATAWIDTH_BUS             = 8,
    parameter int STATE_DATAWIDTH           = 2,
    parameter int BLINK_PRESCALER_DATAWIDTH = 23
) (
    input  logic                                    SC_MATRIX_SCHEDULER_CLOCK_50,
    input  logic                                    SC_MATRIX_SCHEDULER_RESET_InLow,
    input  logic [STATE_DATAWIDTH-1:0]              SC_MATRIX_SCHEDULER_MainState_In,
    input  logic [DATAWIDTH_BUS*DATAWIDTH_BUS-1:0]  SC_MATRIX_SCHEDULER_GameRows_In,
    input  logic                                    SC_MATRIX_SCHEDULER_GameFrameValid_In,
    output logic                                    SC_MATRIX_SCHEDULER_GameFrameAck_Out,
    input  logic [$clog2(DATAWIDTH_BUS)-1:0]        SC_MATRIX_SCHEDULER_DispAddr_In,
    output logic [DATAWIDTH_BUS-1:0]                SC_MATRIX_SCHEDULER_DispData_Out,
    output logic [3:0]                              SC_MATRIX_SCHEDULER_Intensity_Out,
    output logic                                    SC_MATRIX_SCHEDULER_FrameSwap_Out
);

    localparam int FRAME_W = DATAWIDTH_BUS * DATAWIDTH_BUS;
    localparam int ADDR_W  = $clog2(DATAWIDTH_BUS);
    localparam int BLINK_W = BLINK_PRESCALER_DATAWIDTH;

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DATAWIDTH_BUS - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE = {{(BLINK_W-1){1'b0}}, 1'b1};

    sched_state_t        state;
    sched_state_t        state_nxt;
    logic [BLINK_W-1:0]  blink_cnt;
    logic [BLINK_W-1:0]  blink_nxt;
    logic [FRAME_W-1:0]  shadow;
    logic [FRAME_W-1:0]  active;
    logic [FRAME_W-1:0]  src_frame;
    logic                pending;
    logic [ADDR_W-1:0]   prev_addr;
    logic                wrap;
    logic                commit;
    logic [DATAWIDTH_BUS-1:0] col;

    // Next state. The blink counter only runs while already in a game-over
    // state, so entering game-over always starts from a cleared count.
    always_comb begin
        state_nxt = state;
        blink_nxt = '0;
        case (SC_MATRIX_SCHEDULER_MainState_In)
            MAIN_PLAY: state_nxt = SCHED_PLAY;
            MAIN_GAMEOVER: begin
                if (state == SCHED_OVER_ON || state == SCHED_OVER_OFF) begin
                    blink_nxt = blink_cnt + BLINK_ONE;
                    if (&blink_cnt) begin
                        state_nxt = (state == SCHED_OVER_ON) ? SCHED_OVER_OFF : SCHED_OVER_ON;
                    end
                end else begin
                    state_nxt = SCHED_OVER_ON;
                end
            end
            default: state_nxt = SCHED_SPLASH;
        endcase
    end

    // A scan wrap is the controller stepping from the last column back to 0.
    // Frames are only committed while actively playing so the game-over
    // picture stays frozen; pending survives until play resumes.
    assign wrap   = (prev_addr == LAST_ADDR) && (SC_MATRIX_SCHEDULER_DispAddr_In == '0);
    assign commit = wrap && pending && (state == SCHED_PLAY);

    always_comb begin
        src_frame = '0;
        case (state)
            SCHED_SPLASH:  src_frame = SPLASH_FRAME;
            SCHED_PLAY:    src_frame = active;
            SCHED_OVER_ON: src_frame = active;
            default:       src_frame = '0;
        endcase
    end

    sc_matrix_transpose #(
        .DATAWIDTH_BUS (DATAWIDTH_BUS)
    ) u_transpose (
        .frame (src_frame),
        .addr  (SC_MATRIX_SCHEDULER_DispAddr_In),
        .col   (col)
    );

    always_ff @(posedge SC_MATRIX_SCHEDULER_CLOCK_50) begin
        if (!SC_MATRIX_SCHEDULER_RESET_InLow) begin
            state                                <= SCHED_SPLASH;
            blink_cnt                            <= '0;
            shadow                               <= '0;
            active                               <= '0;
            pending                              <= 1'b0;
            prev_addr                            <= '0;
            SC_MATRIX_SCHEDULER_DispData_Out     <= '0;
            SC_MATRIX_SCHEDULER_Intensity_Out    <= INTENSITY_SPLASH;
            SC_MATRIX_SCHEDULER_GameFrameAck_Out <= 1'b0;
            SC_MATRIX_SCHEDULER_FrameSwap_Out    <= 1'b0;
        end else begin
            state                                <= state_nxt;
            blink_cnt                            <= blink_nxt;
            prev_addr                            <= SC_MATRIX_SCHEDULER_DispAddr_In;
            SC_MATRIX_SCHEDULER_DispData_Out     <= col;
            SC_MATRIX_SCHEDULER_Intensity_Out    <= intensity_for(state);
            SC_MATRIX_SCHEDULER_GameFrameAck_Out <= SC_MATRIX_SCHEDULER_GameFrameValid_In;
            SC_MATRIX_SCHEDULER_FrameSwap_Out    <= commit;
            // Commit and capture on the same edge: active takes the old
            // shadow, shadow takes the new frame, and pending stays set.
            if (commit) begin
                active <= shadow;
            end
            if (SC_MATRIX_SCHEDULER_GameFrameValid_In) begin
                shadow  <= SC_MATRIX_SCHEDULER_GameRows_In;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sc_matrix_scheduler.sv
module tb_sc_matrix_scheduler;

    localparam logic [63:0] F81 = {8{8'h81}};
    localparam logic [63:0] FA  = 64'h8040_2010_0804_0201;
    localparam logic [63:0] FB  = 64'h0000_0000_0000_00F0;
    localparam logic [63:0] FC  = {8{8'hFF}};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  main_st;
    logic [63:0] rows;
    logic        valid;
    logic        ack;
    logic [2:0]  addr;
    logic [7:0]  data;
    logic [3:0]  inten;
    logic        swap;

    always #5 clk = ~clk;

    sc_matrix_scheduler #(
        .DATAWIDTH_BUS             (8),
        .STATE_DATAWIDTH           (2),
        .BLINK_PRESCALER_DATAWIDTH (4)
    ) dut (
        .SC_MATRIX_SCHEDULER_CLOCK_50          (clk),
        .SC_MATRIX_SCHEDULER_RESET_InLow       (rst_n),
        .SC_MATRIX_SCHEDULER_MainState_In      (main_st),
        .SC_MATRIX_SCHEDULER_GameRows_In       (rows),
        .SC_MATRIX_SCHEDULER_GameFrameValid_In (valid),
        .SC_MATRIX_SCHEDULER_GameFrameAck_Out  (ack),
        .SC_MATRIX_SCHEDULER_DispAddr_In       (addr),
        .SC_MATRIX_SCHEDULER_DispData_Out      (data),
        .SC_MATRIX_SCHEDULER_Intensity_Out     (inten),
        .SC_MATRIX_SCHEDULER_FrameSwap_Out     (swap)
    );

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic [3:0] inten;
        logic       ack;
        logic       swap;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    // Hand-derived column bytes of the reference frames.
    function automatic logic [7:0] spl_col(input int a);
        logic [7:0] v;
        case (a)
            0: v = 8'h00;
            1: v = 8'h0C;
            2: v = 8'h1E;
            3: v = 8'hBF;
            4: v = 8'h1E;
            5: v = 8'h0C;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] f81_col(input int a);
        return (a == 0 || a == 7) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [7:0] a_col(input int a);
        logic [7:0] one;
        one = 8'h01;
        return one << a;
    endfunction

    function automatic logic [7:0] b_col(input int a);
        return (a < 4) ? 8'h80 : 8'h00;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [1:0] ms, input logic [2:0] a, input logic v,
                        input logic [63:0] rw, input logic [7:0] ed, input logic [3:0] ei,
                        input logic ea, input logic es, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n   = r;
        main_st = ms;
        addr    = a;
        valid   = v;
        rows    = rw;
        e.cyc   = cyc + 1;
        e.data  = ed;
        e.inten = ei;
        e.ack   = ea;
        e.swap  = es;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every queued expectation against the outputs at its cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                if (e.cyc != cyc || data !== e.data || inten !== e.inten || ack !== e.ack || swap !== e.swap) begin
                    miscompares++;
                    $display("FAIL %s cyc=%0d: got data=%h inten=%h ack=%b swap=%b, want data=%h inten=%h ack=%b swap=%b",
                             e.name, cyc, data, inten, ack, swap, e.data, e.inten, e.ack, e.swap);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        main_st = 2'b00;
        addr    = 3'd7;
        valid   = 1'b1;
        rows    = FC;

        // Reset, with valid high: nothing captured, outputs at reset values.
        step(0, 2'b00, 3'd7, 1, FC, 8'h00, 4'h6, 0, 0, "reset");
        step(0, 2'b00, 3'd7, 1, FC, 8'h00, 4'h6, 0, 0, "reset");

        // Splash sweep.
        for (int a = 0; a < 8; a++)
            step(1, 2'b00, 3'(a), 0, 64'h0, spl_col(a), 4'h6, 0, 0, "splash");

        // Enter play with empty active buffer; wrap with nothing pending.
        step(1, 2'b01, 3'd0, 0, 64'h0, spl_col(0), 4'h6, 0, 0, "play_entry");
        for (int a = 1; a < 8; a++)
            step(1, 2'b01, 3'(a), 0, 64'h0, 8'h00, 4'hA, 0, 0, "play_empty");
        step(1, 2'b01, 3'd0, 0, 64'h0, 8'h00, 4'hA, 0, 0, "empty_wrap");

        // Single frame: ack, no change until wrap, then swap and new data.
        step(1, 2'b01, 3'd0, 1, F81, 8'h00, 4'hA, 1, 0, "ack");
        for (int a = 1; a < 8; a++)
            step(1, 2'b01, 3'(a), 0, 64'h0, 8'h00, 4'hA, 0, 0, "pre_commit");
        step(1, 2'b01, 3'd0, 0, 64'h0, 8'h00, 4'hA, 0, 1, "swap1");
        for (int a = 0; a < 8; a++)
            step(1, 2'b01, 3'(a), 0, 64'h0, f81_col(a), 4'hA, 0, 0, "f81_col");

        // Valid on the wrap edge: A committed, B stays pending for the next wrap.
        step(1, 2'b01, 3'd6, 1, FA, f81_col(6), 4'hA, 1, 0, "load_A");
        step(1, 2'b01, 3'd7, 0, 64'h0, f81_col(7), 4'hA, 0, 0, "pre_wrap");
        step(1, 2'b01, 3'd0, 1, FB, f81_col(0), 4'hA, 1, 1, "wrap_valid");
        for (int a = 0; a < 8; a++)
            step(1, 2'b01, 3'(a), 0, 64'h0, a_col(a), 4'hA, 0, 0, "A_col");
        step(1, 2'b01, 3'd0, 0, 64'h0, a_col(0), 4'hA, 0, 1, "swap_B");
        for (int a = 0; a < 8; a++)
            step(1, 2'b01, 3'(a), 0, 64'h0, b_col(a), 4'hA, 0, 0, "B_col");
        step(1, 2'b01, 3'd0, 0, 64'h0, b_col(0), 4'hA, 0, 0, "no_pending_wrap");

        // Pending frame C, then game over: blink 16/16 on frame B, wraps never commit.
        step(1, 2'b01, 3'd1, 1, FC, b_col(1), 4'hA, 1, 0, "load_C");
        for (int k = 0; k <= 48; k++) begin
            int a;
            a = (2 + k) % 8;
            step(1, 2'b10, 3'(a), 0, 64'h0,
                 (k <= 16 || k >= 33) ? b_col(a) : 8'h00,
                 (k == 0) ? 4'hA : 4'hF, 0, 0, "blink");
        end

        // Back to play: the held frame C commits on the next wrap.
        step(1, 2'b01, 3'd3, 0, 64'h0, 8'h00, 4'hF, 0, 0, "over_exit");
        for (int a = 4; a < 8; a++)
            step(1, 2'b01, 3'(a), 0, 64'h0, b_col(a), 4'hA, 0, 0, "resume");
        step(1, 2'b01, 3'd0, 0, 64'h0, b_col(0), 4'hA, 0, 1, "late_commit");
        step(1, 2'b01, 3'd1, 0, 64'h0, 8'hFF, 4'hA, 0, 0, "C_col");
        step(1, 2'b01, 3'd2, 0, 64'h0, 8'hFF, 4'hA, 0, 0, "C_col");

        // Reset mid-scan with a pending frame: everything cleared, no swap afterwards.
        step(1, 2'b01, 3'd3, 1, F81, 8'hFF, 4'hA, 1, 0, "load_D");
        step(1, 2'b01, 3'd4, 0, 64'h0, 8'hFF, 4'hA, 0, 0, "pre_reset");
        step(0, 2'b01, 3'd5, 1, FC, 8'h00, 4'h6, 0, 0, "mid_reset");
        step(0, 2'b01, 3'd6, 0, 64'h0, 8'h00, 4'h6, 0, 0, "mid_reset");
        step(1, 2'b01, 3'd7, 0, 64'h0, spl_col(7), 4'h6, 0, 0, "post_reset");
        step(1, 2'b01, 3'd0, 0, 64'h0, 8'h00, 4'hA, 0, 0, "post_reset_wrap");
        step(1, 2'b01, 3'd1, 0, 64'h0, 8'h00, 4'hA, 0, 0, "active_cleared");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
